// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side cache bus master: C1 command codes,
// FSM state type and command classification / read-size helpers.
package cpu_bus_pkg;

    localparam logic [2:0] C1_NOP        = 3'd0;
    localparam logic [2:0] C1_READ8      = 3'd1;
    localparam logic [2:0] C1_READ16     = 3'd2;
    localparam logic [2:0] C1_READ32     = 3'd3;
    localparam logic [2:0] C1_INVALIDATE = 3'd4;
    localparam logic [2:0] C1_WRITE8     = 3'd5;
    localparam logic [2:0] C1_WRITE16    = 3'd6;
    localparam logic [2:0] C1_WRITE32    = 3'd7;
    localparam logic [2:0] C1_RESPONSE   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_HI,
        S_ADDR_LO,
        S_WDATA,
        S_TURN,
        S_WAIT_RSP,
        S_RDATA,
        S_DONE
    } state_t;

    function automatic logic is_read(input logic [2:0] cmd);
        return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
    endfunction

    function automatic logic is_write(input logic [2:0] cmd);
        return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
    endfunction

    // Narrow reads return only the low byte / half-word of the assembled word.
    function automatic logic [63:0] read_mask(input logic [2:0] cmd);
        case (cmd)
            C1_READ8:  return 64'h0000_0000_0000_00FF;
            C1_READ16: return 64'h0000_0000_0000_FFFF;
            default:   return '1;
        endcase
    endfunction

endpackage

// File: rtl/cpu_bus_timer.sv
// Loadable down-counter for the response-wait limit; o_expired is high
// while the count sits at zero.
module cpu_bus_timer #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/cpu_bus_master.sv
// CPU-side master for the shared cache bus: serialises a request into address
// and write-data beats, then collects the response. Optional wait limit: CPU_BUS_TIMEOUT_EN.
module cpu_bus_master
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int OFFSET_W = 5,
    parameter int BUS_W    = 16,
    parameter int WORD_W   = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_req_valid,
    output logic                       o_req_ready,
    input  logic [2:0]                 i_req_cmd,
    input  logic [ADDR_W-1:0]          i_req_addr,
    input  logic [WORD_W-1:0]          i_req_wdata,
    output logic                       o_rsp_valid,
    output logic [WORD_W-1:0]          o_rsp_rdata,
    output logic                       o_rsp_err,
    output logic                       o_busy,
    output logic [ADDR_W-OFFSET_W-1:0] o_a1_out,
    output logic [2:0]                 o_c1_out,
    output logic                       o_c1_oe,
    input  logic [2:0]                 i_c1_in,
    output logic [BUS_W-1:0]           o_d1_out,
    output logic                       o_d1_oe,
    input  logic [BUS_W-1:0]           i_d1_in
);

    localparam int A1_W   = ADDR_W - OFFSET_W;
    localparam int NB     = WORD_W / BUS_W;
    localparam int BEAT_W = $clog2(NB + 1);
    localparam logic [BEAT_W-1:0] BEAT_NB   = BEAT_W'(NB);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NB - 1);

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_cmd, w_cmd_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [WORD_W-1:0]   r_wsh, w_wsh_nxt;
    logic [WORD_W-1:0]   r_rsh, w_rsh_nxt;
    logic [BEAT_W-1:0]   r_beat, w_beat_nxt;
    logic [A1_W-1:0]     r_a1, w_a1_nxt;
    logic [2:0]          r_c1, w_c1_nxt;
    logic                r_c1_oe, w_c1_oe_nxt;
    logic [BUS_W-1:0]    r_d1, w_d1_nxt;
    logic                r_d1_oe, w_d1_oe_nxt;
    logic                r_rsp_valid, w_rsp_valid_nxt;
    logic [WORD_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
    logic                r_rsp_err, w_rsp_err_nxt;
    logic                w_wr_more;
    logic                w_tmo;
    logic [WORD_W-1:0]   w_rsh_in;
    logic [WORD_W-1:0]   w_mask;

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic w_tmr_expired;

    cpu_bus_timer #(.W(TMR_W)) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (r_state == S_TURN),
        .i_load_val (TMR_W'(TIMEOUT - 1)),
        .i_en       (r_state == S_WAIT_RSP),
        .o_expired  (w_tmr_expired)
    );

    assign w_tmo = (r_state == S_WAIT_RSP) && w_tmr_expired;
`else
    assign w_tmo = 1'b0;
`endif

    assign w_wr_more = is_write(r_cmd) && (r_beat < BEAT_NB);
    assign w_rsh_in  = (r_rsh << BUS_W) | WORD_W'(i_d1_in);
    assign w_mask    = WORD_W'(read_mask(r_cmd));

    // Outputs are computed for the state being entered and registered with it.
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_nxt       = r_cmd;
        w_addr_nxt      = r_addr;
        w_wsh_nxt       = r_wsh;
        w_rsh_nxt       = r_rsh;
        w_beat_nxt      = r_beat;
        w_a1_nxt        = '0;
        w_c1_nxt        = '0;
        w_c1_oe_nxt     = 1'b0;
        w_d1_nxt        = '0;
        w_d1_oe_nxt     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_cmd_nxt  = i_req_cmd;
                    w_addr_nxt = i_req_addr;
                    w_beat_nxt = '0;
                    if (i_req_cmd == C1_NOP) begin
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = S_ADDR_HI;
                        w_c1_nxt    = i_req_cmd;
                        w_c1_oe_nxt = 1'b1;
                        w_a1_nxt    = i_req_addr[ADDR_W-1:OFFSET_W];
                        if (is_write(i_req_cmd)) begin
                            w_d1_oe_nxt = 1'b1;
                            w_d1_nxt    = i_req_wdata[WORD_W-1 -: BUS_W];
                            w_wsh_nxt   = i_req_wdata << BUS_W;
                            w_beat_nxt  = BEAT_W'(1);
                        end
                    end
                end
            end
            S_ADDR_HI: begin
                w_state_nxt = S_ADDR_LO;
                w_c1_nxt    = r_cmd;
                w_c1_oe_nxt = 1'b1;
                w_a1_nxt    = A1_W'(r_addr[OFFSET_W-1:0]);
                if (w_wr_more) begin
                    w_d1_oe_nxt = 1'b1;
                    w_d1_nxt    = r_wsh[WORD_W-1 -: BUS_W];
                    w_wsh_nxt   = r_wsh << BUS_W;
                    w_beat_nxt  = r_beat + 1'b1;
                end
            end
            S_ADDR_LO, S_WDATA: begin
                if (w_wr_more) begin
                    w_state_nxt = S_WDATA;
                    w_c1_nxt    = r_cmd;
                    w_c1_oe_nxt = 1'b1;
                    w_d1_oe_nxt = 1'b1;
                    w_d1_nxt    = r_wsh[WORD_W-1 -: BUS_W];
                    w_wsh_nxt   = r_wsh << BUS_W;
                    w_beat_nxt  = r_beat + 1'b1;
                end else begin
                    w_state_nxt = S_TURN;
                    w_beat_nxt  = '0;
                end
            end
            S_TURN: begin
                w_state_nxt = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (i_c1_in == C1_RESPONSE) begin
                    if (is_read(r_cmd)) begin
                        w_rsh_nxt  = w_rsh_in;
                        w_beat_nxt = BEAT_W'(1);
                        if (BEAT_LAST == '0) begin
                            w_state_nxt     = S_DONE;
                            w_rsp_valid_nxt = 1'b1;
                            w_rsp_err_nxt   = 1'b0;
                            w_rsp_rdata_nxt = w_rsh_in & w_mask;
                        end else begin
                            w_state_nxt = S_RDATA;
                        end
                    end else begin
                        w_state_nxt     = S_DONE;
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b0;
                    end
                end else if (w_tmo) begin
                    w_state_nxt     = S_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_rdata_nxt = '0;
                end
            end
            S_RDATA: begin
                w_rsh_nxt  = w_rsh_in;
                w_beat_nxt = r_beat + 1'b1;
                if (r_beat == BEAT_LAST) begin
                    w_state_nxt     = S_DONE;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = 1'b0;
                    w_rsp_rdata_nxt = w_rsh_in & w_mask;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_wsh       <= '0;
            r_rsh       <= '0;
            r_beat      <= '0;
            r_a1        <= '0;
            r_c1        <= '0;
            r_c1_oe     <= 1'b0;
            r_d1        <= '0;
            r_d1_oe     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_addr      <= w_addr_nxt;
            r_wsh       <= w_wsh_nxt;
            r_rsh       <= w_rsh_nxt;
            r_beat      <= w_beat_nxt;
            r_a1        <= w_a1_nxt;
            r_c1        <= w_c1_nxt;
            r_c1_oe     <= w_c1_oe_nxt;
            r_d1        <= w_d1_nxt;
            r_d1_oe     <= w_d1_oe_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_busy      = (r_state != S_IDLE);
    assign o_a1_out    = r_a1;
    assign o_c1_out    = r_c1;
    assign o_c1_oe     = r_c1_oe;
    assign o_d1_out    = r_d1;
    assign o_d1_oe     = r_d1_oe;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master: vector table plus a response
// scoreboard, with hand-written reset-abort and wait-limit sequences.
module tb_cpu_bus_master;

    localparam int ADDR_W   = 20;
    localparam int OFFSET_W = 5;
    localparam int BUS_W    = 16;
    localparam int WORD_W   = 32;
    localparam int TIMEOUT  = 4;

    logic                       clk = 1'b0;
    logic                       i_reset;
    logic                       i_req_valid;
    logic                       o_req_ready;
    logic [2:0]                 i_req_cmd;
    logic [ADDR_W-1:0]          i_req_addr;
    logic [WORD_W-1:0]          i_req_wdata;
    logic                       o_rsp_valid;
    logic [WORD_W-1:0]          o_rsp_rdata;
    logic                       o_rsp_err;
    logic                       o_busy;
    logic [ADDR_W-OFFSET_W-1:0] o_a1_out;
    logic [2:0]                 o_c1_out;
    logic                       o_c1_oe;
    logic [2:0]                 i_c1_in;
    logic [BUS_W-1:0]           o_d1_out;
    logic                       o_d1_oe;
    logic [BUS_W-1:0]           i_d1_in;

    always #5 clk = ~clk;

    cpu_bus_master #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .BUS_W(BUS_W),
        .WORD_W(WORD_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_cmd   (i_req_cmd),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_rdata (o_rsp_rdata),
        .o_rsp_err   (o_rsp_err),
        .o_busy      (o_busy),
        .o_a1_out    (o_a1_out),
        .o_c1_out    (o_c1_out),
        .o_c1_oe     (o_c1_oe),
        .i_c1_in     (i_c1_in),
        .o_d1_out    (o_d1_out),
        .o_d1_oe     (o_d1_oe),
        .i_d1_in     (i_d1_in)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [15:0] b0;
        logic [15:0] b1;
        int          delay;
        bit          stray;
        logic [14:0] hi;
        logic [14:0] lo;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    vec_t        vecs[8];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL sb_unexpected: rsp_valid with rdata 0x%08h, required no response", o_rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk("sb_rdata", o_rsp_rdata, e.rdata);
                chk("sb_err", 32'(o_rsp_err), 32'(e.err));
            end
        end
    end

    task automatic drive_req(input logic [2:0] cmd, input logic [19:0] addr, input logic [31:0] wdata);
        i_req_valid = 1'b1;
        i_req_cmd   = cmd;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        @(posedge clk);
        #1 i_req_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit   is_wr;
        bit   is_rd;
        bit   got;
        exp_t e;
        is_wr = (v.cmd >= 3'd5);
        is_rd = (v.cmd != 3'd0) && (v.cmd < 3'd4);
        got   = 1'b0;
        chk("ready_idle", 32'(o_req_ready), 32'd1);
        if (is_rd) last_rdata = v.rdata;
        e.rdata = last_rdata;
        e.err   = 1'b0;
        sb.push_back(e);
        drive_req(v.cmd, v.addr, v.wdata);
        @(negedge clk);
        if (v.cmd == 3'd0) begin
            chk("nop_valid", 32'(o_rsp_valid), 32'd1);
            chk("nop_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
            @(negedge clk);
            chk("nop_ready", 32'(o_req_ready), 32'd1);
            return;
        end
        chk("hi_a1", 32'(o_a1_out), 32'(v.hi));
        chk("hi_c1", 32'(o_c1_out), 32'(v.cmd));
        chk("hi_c1_oe", 32'(o_c1_oe), 32'd1);
        chk("hi_d1_oe", 32'(o_d1_oe), 32'(is_wr));
        chk("hi_d1", 32'(o_d1_out), is_wr ? 32'(v.wdata[31:16]) : 32'd0);
        chk("hi_busy", 32'({o_busy, o_req_ready}), 32'b10);
        if (v.stray) i_c1_in = 3'd7;
        @(negedge clk);
        i_c1_in = 3'd0;
        chk("lo_a1", 32'(o_a1_out), 32'(v.lo));
        chk("lo_c1", 32'({o_c1_oe, o_c1_out}), 32'({1'b1, v.cmd}));
        chk("lo_d1_oe", 32'(o_d1_oe), 32'(is_wr));
        chk("lo_d1", 32'(o_d1_out), is_wr ? 32'(v.wdata[15:0]) : 32'd0);
        @(negedge clk);
        chk("turn_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
        chk("turn_out", 32'({o_c1_out, o_d1_out}), 32'd0);
        if (v.stray) i_c1_in = 3'd7;
        for (int i = 0; i < v.delay; i++) begin
            @(posedge clk);
            #1 i_c1_in = 3'd0;
            @(negedge clk);
            chk("wait_valid", 32'(o_rsp_valid), 32'd0);
            chk("wait_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
        end
        @(posedge clk);
        #1 i_c1_in = 3'd7;
        i_d1_in = v.b0;
        if (is_rd) begin
            @(posedge clk);
            #1 i_c1_in = 3'd0;
            i_d1_in = v.b1;
            @(negedge clk);
            chk("rdata_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
            @(posedge clk);
            #1 i_d1_in = '0;
            @(negedge clk);
            chk("rd_valid_cycle", 32'(o_rsp_valid), 32'd1);
        end else begin
            @(posedge clk);
            #1 i_c1_in = 3'd0;
            i_d1_in = '0;
            for (int k = 0; k < 3 && !got; k++) begin
                @(negedge clk);
                if (o_rsp_valid === 1'b1) got = 1'b1;
            end
            chk("wr_valid", 32'(got), 32'd1);
        end
        chk("done_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
        @(negedge clk);
        chk("after_ready", 32'({o_req_ready, o_rsp_valid}), 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3'd3, 20'h12345, 32'h0,        16'hDEAD, 16'hBEEF, 0, 1'b0, 15'h091A, 15'h05, 32'hDEADBEEF};
        vecs[1] = '{3'd7, 20'h00020, 32'hCAFEF00D, 16'h0,    16'h0,    0, 1'b0, 15'h0001, 15'h00, 32'h0};
        vecs[2] = '{3'd1, 20'h0ABCD, 32'h0,        16'h1234, 16'h56AB, 0, 1'b0, 15'h055E, 15'h0D, 32'h000000AB};
        vecs[3] = '{3'd2, 20'hFFFFF, 32'h0,        16'h1111, 16'h2222, 2, 1'b0, 15'h7FFF, 15'h1F, 32'h00002222};
        vecs[4] = '{3'd4, 20'h00400, 32'h0,        16'h0,    16'h0,    1, 1'b0, 15'h0020, 15'h00, 32'h0};
        vecs[5] = '{3'd0, 20'h00000, 32'h0,        16'h0,    16'h0,    0, 1'b0, 15'h0000, 15'h00, 32'h0};
        vecs[6] = '{3'd5, 20'h7FFE1, 32'h000000A5, 16'h0,    16'h0,    1, 1'b1, 15'h3FFF, 15'h01, 32'h0};
        vecs[7] = '{3'd3, 20'h00000, 32'h0,        16'h0F0F, 16'hA5A5, 1, 1'b1, 15'h0000, 15'h00, 32'h0F0FA5A5};

        i_reset     = 1'b1;
        i_req_valid = 1'b0;
        i_req_cmd   = '0;
        i_req_addr  = '0;
        i_req_wdata = '0;
        i_c1_in     = '0;
        i_d1_in     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_busy", 32'({o_req_ready, o_busy}), 32'b10);
        chk("rst_rsp", 32'({o_rsp_valid, o_rsp_err}), 32'd0);
        chk("rst_rdata", o_rsp_rdata, 32'd0);
        chk("rst_bus", 32'({o_a1_out, o_c1_out, o_c1_oe, o_d1_oe}), 32'd0);
        chk("rst_d1", 32'(o_d1_out), 32'd0);
        i_reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Reset in the middle of a READ32 aborts it silently.
        drive_req(3'd3, 20'h12345, 32'h0);
        @(negedge clk);
        chk("abort_pre_oe", 32'(o_c1_oe), 32'd1);
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 i_reset = 1'b0;
        last_rdata = 32'h0;
        @(negedge clk);
        chk("abort_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
        chk("abort_ready", 32'({o_req_ready, o_busy, o_rsp_valid}), 32'b100);
        chk("abort_rdata", o_rsp_rdata, 32'd0);
        repeat (6) @(negedge clk);
        chk("abort_idle", 32'(o_req_ready), 32'd1);
        run_txn(vecs[0]);

`ifdef CPU_BUS_TIMEOUT_EN
        begin
            exp_t e;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            sb.push_back(e);
            last_rdata = 32'h0;
            drive_req(3'd3, 20'h00100, 32'h0);
            repeat (3) @(negedge clk);
            chk("tmo_turn_oe", 32'({o_c1_oe, o_d1_oe}), 32'd0);
            for (int i = 0; i < TIMEOUT; i++) begin
                @(negedge clk);
                chk("tmo_waiting", 32'(o_rsp_valid), 32'd0);
            end
            @(negedge clk);
            chk("tmo_valid", 32'(o_rsp_valid), 32'd1);
            chk("tmo_err", 32'(o_rsp_err), 32'd1);
            chk("tmo_rdata", o_rsp_rdata, 32'd0);
            @(negedge clk);
            chk("tmo_ready", 32'(o_req_ready), 32'd1);
            run_txn(vecs[2]);
        end
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
